sysid_arbiter: RTL

SYSID_ARBITER -- requirements
Module: sysid_arbiter

---
 rtl/sysid_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sysid_arbiter.sv
// sysid_arbiter: two-master round-robin arbiter in front of a combinational
// system-ID slave (word 0 = ID, word 1 = timestamp).
// Every transaction takes three cycles: grant (IDLE), command accept (ISSUE)
// and response strobe (RESP).
// Optional feature macro SYSID_ARB_CACHE_EN: keeps a one-word cache per
// address. Once an address has been read from the slave, later reads of it
// are served from the cache without raising s_read. Handshake timing stays
// the same.

module sysid_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_read,
   input  logic        m0_address,
   output logic        m0_waitrequest,
   output logic        m0_readdatavalid,
   output logic [31:0] m0_readdata,
   input  logic        m1_read,
   input  logic        m1_address,
   output logic        m1_waitrequest,
   output logic        m1_readdatavalid,
   output logic [31:0] m1_readdata,
   output logic        s_read,
   output logic        s_address,
   input  logic [31:0] s_readdata,
   output logic [15:0] access_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;

   // grant_q is both the current owner and the last-granted master
   // (0 = m0, 1 = m1); round-robin favours the other master on a tie.
   logic        grant_q;
   logic        grant_d;
   logic        addr_q;
   logic        addr_d;
   logic [31:0] data_q;
   logic [15:0] access_count_q;
   logic        cache_hit;
   logic [31:0] fetch_data;

`ifdef SYSID_ARB_CACHE_EN
   logic [31:0] cache_data_q [2];
   logic [1:0]  cache_valid_q;

   assign cache_hit  = cache_valid_q[addr_q];
   assign fetch_data = cache_hit ? cache_data_q[addr_q] : s_readdata;

   // Fill the cache entry on the first real slave read of each address.
   always_ff @(posedge clock) begin
      if (reset) begin
         cache_valid_q <= 2'b00;
      end else if (state_q == ISSUE && !cache_hit) begin
         cache_valid_q[addr_q] <= 1'b1;
         cache_data_q[addr_q]  <= s_readdata;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign fetch_data = s_readdata;
`endif

   // State register, plus the grant and address latched when a request wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 1'b1;
         addr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state logic, arbitration, and handshake strobes. Reset forces the
   // strobes inactive in the same cycle because the reset itself is synchronous.
   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      addr_d           = addr_q;
      m0_waitrequest   = 1'b1;
      m1_waitrequest   = 1'b1;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
      s_read           = 1'b0;

      case (state_q)
         IDLE: begin
            if (m0_read || m1_read) begin
               if (m0_read && m1_read) begin
                  grant_d = ~grant_q;
               end else begin
                  grant_d = m1_read;
               end
               addr_d  = grant_d ? m1_address : m0_address;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (grant_q) begin
               m1_waitrequest = 1'b0;
            end else begin
               m0_waitrequest = 1'b0;
            end
            s_read  = ~cache_hit;
            state_d = RESP;
         end
         RESP: begin
            if (grant_q) begin
               m1_readdatavalid = 1'b1;
            end else begin
               m0_readdatavalid = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (reset) begin
         m0_waitrequest   = 1'b1;
         m1_waitrequest   = 1'b1;
         m0_readdatavalid = 1'b0;
         m1_readdatavalid = 1'b0;
         s_read           = 1'b0;
      end
   end

   // Capture the response word at the end of ISSUE. It is shared by both masters.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q <= 32'h0000_0000;
      end else if (state_q == ISSUE) begin
         data_q <= fetch_data;
      end
   end

   // Count real slave reads, saturating so the counter never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         access_count_q <= 16'h0000;
      end else if (s_read && access_count_q != 16'hFFFF) begin
         access_count_q <= access_count_q + 16'h0001;
      end
   end

   assign s_address    = addr_q;
   assign m0_readdata  = data_q;
   assign m1_readdata  = data_q;
   assign access_count = access_count_q;

endmodule
